render_rect_ctrl: RTL and testbench
===================================

# render_rect_ctrl

Control FSM for the 4x4 rectangle render datapath. Two draw requesters share the single datapath through a round-robin arbiter. For the granted request the block:
- latches the request's coordinates and colour;
- steps the datapath through the X load, the Y load and a 16-cycle pixel count;
- reports completion with a one-cycle done pulse.

Its outputs connect directly to the datapath's `data_in`, `ld_x`, `ld_y` and `start_count` inputs. Colour goes straight to the VGA adapter.

## Interface
Parameters:
- `PIXELS`, 16: pixels per rectangle (4x4); sets the DRAW state length.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `req`  in  2  draw request, one bit per requester; held high until acked.
- `x0`, `x1`  in  7 each  X origin of requester 0 / 1.
- `y0`, `y1`  in  7 each  Y origin of requester 0 / 1.
- `col0`, `col1`  in  3 each  colour of requester 0 / 1.
- `ack`  out  2  one-cycle pulse: request accepted and operands latched.
- `data_out`  out  7  to datapath `data_in`.
- `ld_x`, `ld_y`  out  1 each  datapath register load strobes.
- `start_count`  out  1  datapath counter enable.
- `colour`  out  3  latched colour of the request in progress.
- `pix_idx`  out  4  current pixel index during DRAW.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse after the last pixel.

## Operation
States and transitions:
- **IDLE**
  - If `req != 0`, the arbiter picks a winner `w`.
  - Latch `x_w`, `y_w` and `col_w` into internal registers.
  - Pulse `ack[w]`, update `last_grant <= w`, then go to LD_X.
  - If `req == 0`, stay in IDLE.
- **LD_X**: `data_out = x_lat`, `ld_x = 1`; then go to LD_Y.
- **LD_Y**: `data_out = y_lat`, `ld_y = 1`; then go to DRAW.
- **DRAW**
  - `start_count = 1`.
  - `pix_idx` counts 0 to PIXELS-1, one per cycle.
  - After the cycle with `pix_idx == PIXELS-1`, go to DONE.
- **DONE**: `done = 1`; then go to IDLE.

Arbitration:
- Only one request is pending: it wins.
- Both requests are pending: the requester not equal to `last_grant` wins.
- `last_grant` resets to 1, so requester 0 wins the first tie.

Other rules:
- `req` is sampled only in IDLE. Operand changes after `ack` have no effect on the draw in progress.
- `data_out` is 0 outside LD_X and LD_Y.
- `pix_idx` is 0 outside DRAW.
- `colour` holds its latched value until the next `ack`.
- All outputs are registered or decoded from registered state only. No combinational path from `req` or any operand input to any output except `ack`.
- `ack` is decoded from state and `req` in IDLE.

## Timing
Reset values (`resetn` low, immediate):
- state IDLE, `last_grant = 1`.
- `ack`, `data_out`, `ld_x`, `ld_y`, `start_count`, `pix_idx`, `colour`, `busy`, `done` all 0.

Latency for a request seen in IDLE at cycle T:
- `ack` in cycle T.
- LD_X at T+1, LD_Y at T+2.
- DRAW from T+3 to T+18 (16 cycles).
- DONE at T+19.
- IDLE at T+20, where a new grant is possible.
- Throughput: one rectangle every 20 cycles under continuous requests.

Boundary conditions:
- **Reset mid-operation**: abort immediately to IDLE. The aborted request is not re-acked; the requester must re-assert `req`.
- **`req` dropped before ack**: the request is ignored with no side effect.
- **Request arriving while busy**: not acked until IDLE.
- **`pix_idx` wrap**: it must never wrap within DRAW. It is forced to 0 on exit.
- **Operand range**: `x = 127`, `y = 127` pass through unmodified. Clipping is not this block's job.

## Structure
- Shared package: state encoding constants (IDLE, LD_X, LD_Y, DRAW, DONE as 3-bit localparams), the PIXELS default, and coordinate/colour width constants.
- One sub-module, `rr_arbiter2`: 2-input round-robin arbiter.
  - Inputs: `req[1:0]`, `last_grant`, `enable`.
  - Outputs: `grant[1:0]`, one-hot or zero.
  - The FSM, operand latches and pixel counter stay in `render_rect_ctrl`.

## Test plan
- **Reset**: hold `resetn` low with `req = 2'b11` → all outputs 0 and no `ack`. After release → `ack = 2'b01` on the first IDLE cycle.
- **Single draw**: `req[0]` with `x0 = 10`, `y0 = 20`, `col0 = 3'b101` → `ack[0]` at T. `ld_x` with `data_out = 10` at T+1. `ld_y` with `data_out = 20` at T+2. `start_count` for exactly 16 cycles with `pix_idx` 0 to 15. `done` at T+19. `colour = 5` throughout.
- **Round-robin**: `req = 2'b11` held continuously → acks alternate 0,1,0,1 at 20-cycle spacing; no requester is granted twice in a row.
- **Late request**: `req[1]` raised at T+5 during requester 0's draw → `ack[1]` at T+20, not earlier. Requester 0's operands changed after its ack do not alter `data_out`.
- **Mid-draw reset**: `resetn` low at T+10 → outputs 0 in the same cycle. After release with `req = 0` → `busy = 0`, and no `done` pulse is ever seen for the aborted draw.
- **Operand limits**: `x1 = 127`, `y1 = 127` → `data_out = 7'h7F` in LD_X and in LD_Y.

Source files
------------

// File: rtl/render_rect_ctrl_pkg.sv
// Shared constants and state encoding for the 4x4 rectangle render controller.
package render_rect_ctrl_pkg;

    localparam int COORD_W        = 7;
    localparam int COL_W          = 3;
    localparam int IDX_W          = 4;
    localparam int PIXELS_DEFAULT = 16;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_LD_X = 3'd1;
    localparam logic [2:0] ST_LD_Y = 3'd2;
    localparam logic [2:0] ST_DRAW = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE = ST_IDLE,
        S_LD_X = ST_LD_X,
        S_LD_Y = ST_LD_Y,
        S_DRAW = ST_DRAW,
        S_DONE = ST_DONE
    } state_t;

endpackage

// File: rtl/render_rect_ctrl_if.sv
// Requester and datapath signal bundle for render_rect_ctrl.
interface render_rect_ctrl_if;
    import render_rect_ctrl_pkg::*;

    logic [1:0]         req;
    logic [COORD_W-1:0] x0;
    logic [COORD_W-1:0] x1;
    logic [COORD_W-1:0] y0;
    logic [COORD_W-1:0] y1;
    logic [COL_W-1:0]   col0;
    logic [COL_W-1:0]   col1;
    logic [1:0]         ack;
    logic [COORD_W-1:0] data_out;
    logic               ld_x;
    logic               ld_y;
    logic               start_count;
    logic [COL_W-1:0]   colour;
    logic [IDX_W-1:0]   pix_idx;
    logic               busy;
    logic               done;

    modport master (
        output req, x0, x1, y0, y1, col0, col1,
        input  ack, data_out, ld_x, ld_y, start_count, colour, pix_idx, busy, done
    );

    modport slave (
        input  req, x0, x1, y0, y1, col0, col1,
        output ack, data_out, ld_x, ld_y, start_count, colour, pix_idx, busy, done
    );

endinterface

// File: rtl/render_rect_ctrl_arbiter.sv
// Two-input round-robin arbiter; on a tie the requester not granted last time wins.
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    input  logic       enable,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (enable) begin
            case (req)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = last_grant ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end
    end

endmodule

// File: rtl/render_rect_ctrl.sv
// Control FSM for the rectangle render datapath: arbitrates two requesters,
// latches operands, then sequences X load, Y load and the pixel count.
module render_rect_ctrl
    import render_rect_ctrl_pkg::*;
#(
    parameter int PIXELS = PIXELS_DEFAULT
) (
    input  logic              clk,
    input  logic              resetn,
    render_rect_ctrl_if.slave bus
);

    state_t             state;
    state_t             state_next;
    logic               last_grant;
    logic [COORD_W-1:0] x_lat;
    logic [COORD_W-1:0] y_lat;
    logic [COL_W-1:0]   col_lat;
    logic [IDX_W-1:0]   pix_cnt;
    logic [1:0]         grant;
    logic               arb_en;
    logic               last_pix;
    logic [COORD_W-1:0] data_out;
    logic               ld_x;
    logic               ld_y;
    logic               start_count;
    logic               done;

    // Gating with resetn keeps ack quiet while reset is held even though req may be high.
    assign arb_en   = (state == S_IDLE) && resetn;
    assign last_pix = (pix_cnt == IDX_W'(PIXELS - 1));

    rr_arbiter2 u_arb (
        .req        (bus.req),
        .last_grant (last_grant),
        .enable     (arb_en),
        .grant      (grant)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        data_out    = '0;
        ld_x        = 1'b0;
        ld_y        = 1'b0;
        start_count = 1'b0;
        done        = 1'b0;
        case (state)
            S_IDLE: begin
                if (grant != 2'b00) begin
                    state_next = S_LD_X;
                end
            end
            S_LD_X: begin
                data_out   = x_lat;
                ld_x       = 1'b1;
                state_next = S_LD_Y;
            end
            S_LD_Y: begin
                data_out   = y_lat;
                ld_y       = 1'b1;
                state_next = S_DRAW;
            end
            S_DRAW: begin
                start_count = 1'b1;
                if (last_pix) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            x_lat      <= '0;
            y_lat      <= '0;
            col_lat    <= '0;
            last_grant <= 1'b1;
        end else if (grant[0]) begin
            x_lat      <= bus.x0;
            y_lat      <= bus.y0;
            col_lat    <= bus.col0;
            last_grant <= 1'b0;
        end else if (grant[1]) begin
            x_lat      <= bus.x1;
            y_lat      <= bus.y1;
            col_lat    <= bus.col1;
            last_grant <= 1'b1;
        end
    end

    // Counter only advances inside DRAW and is cleared on the last pixel so it never wraps.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pix_cnt <= '0;
        end else if ((state == S_DRAW) && !last_pix) begin
            pix_cnt <= pix_cnt + 1'b1;
        end else begin
            pix_cnt <= '0;
        end
    end

    assign bus.ack         = grant;
    assign bus.data_out    = data_out;
    assign bus.ld_x        = ld_x;
    assign bus.ld_y        = ld_y;
    assign bus.start_count = start_count;
    assign bus.done        = done;
    assign bus.colour      = col_lat;
    assign bus.pix_idx     = pix_cnt;
    assign bus.busy        = (state != S_IDLE);

endmodule

// File: tb/tb_render_rect_ctrl.sv
// Scoreboard bench for render_rect_ctrl: expected draws are queued at stimulus time
// and a negedge monitor walks each granted draw through its 20-cycle sequence.
module tb_render_rect_ctrl;

    typedef struct {
        logic [1:0] ack;
        logic [6:0] x;
        logic [6:0] y;
        logic [2:0] col;
        int         gap;
    } exp_t;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    exp_t sb[$];
    exp_t cur;
    int   checks = 0;
    int   errors = 0;
    int   phase = -1;
    int   idle_cnt = 0;

    always #5 clk = ~clk;

    render_rect_ctrl_if bus ();

    render_rect_ctrl #(.PIXELS(16)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, want %0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] req,
                                 input logic [6:0] x0, input logic [6:0] y0, input logic [2:0] c0,
                                 input logic [6:0] x1, input logic [6:0] y1, input logic [2:0] c1);
        bus.req  = req;
        bus.x0   = x0;
        bus.y0   = y0;
        bus.col0 = c0;
        bus.x1   = x1;
        bus.y1   = y1;
        bus.col1 = c1;
    endtask

    task automatic pushExp(input logic [1:0] ack, input logic [6:0] x, input logic [6:0] y,
                           input logic [2:0] col, input int gap);
        exp_t e;
        e.ack = ack;
        e.x   = x;
        e.y   = y;
        e.col = col;
        e.gap = gap;
        sb.push_back(e);
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic waitPopped(input string tag, input int budget);
        int k = 0;
        while (sb.size() != 0 && k < budget) begin
            cycles(1);
            k++;
        end
        checkOutput(tag, 32'(sb.size()), 32'd0);
    endtask

    task automatic waitIdle(input string tag, input int budget);
        int k = 0;
        while ((sb.size() != 0 || phase >= 0) && k < budget) begin
            cycles(1);
            k++;
        end
        checkOutput(tag, 32'(phase < 0 && sb.size() == 0), 32'd1);
    endtask

    // Monitor: phase 0 is the ack cycle, 1 LD_X, 2 LD_Y, 3..18 DRAW, 19 DONE.
    always @(negedge clk) begin
        if (!resetn) begin
            checkOutput("reset_outputs",
                32'({bus.ack, bus.data_out, bus.ld_x, bus.ld_y, bus.start_count,
                     bus.pix_idx, bus.colour, bus.busy, bus.done}), 32'd0);
            phase    = -1;
            idle_cnt = 0;
        end else if (phase < 0) begin
            checkOutput("idle_quiet",
                32'({bus.busy, bus.done, bus.ld_x, bus.ld_y, bus.start_count,
                     bus.pix_idx, bus.data_out}), 32'd0);
            if (bus.ack != 2'b00) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_ack", 32'(bus.ack), 32'd0);
                end else begin
                    cur = sb.pop_front();
                    checkOutput("ack_grant", 32'(bus.ack), 32'(cur.ack));
                    if (cur.gap >= 0) begin
                        checkOutput("ack_gap", 32'(idle_cnt), 32'(cur.gap));
                    end
                    phase = 1;
                end
            end else begin
                idle_cnt++;
            end
        end else begin
            checkOutput("busy_ack_quiet", 32'({bus.ack, bus.busy}), 32'({2'b00, 1'b1}));
            checkOutput("colour", 32'(bus.colour), 32'(cur.col));
            if (phase == 1) begin
                checkOutput("ld_x_cycle",
                    32'({bus.ld_x, bus.ld_y, bus.start_count, bus.done, bus.pix_idx, bus.data_out}),
                    32'({1'b1, 1'b0, 1'b0, 1'b0, 4'd0, cur.x}));
            end else if (phase == 2) begin
                checkOutput("ld_y_cycle",
                    32'({bus.ld_x, bus.ld_y, bus.start_count, bus.done, bus.pix_idx, bus.data_out}),
                    32'({1'b0, 1'b1, 1'b0, 1'b0, 4'd0, cur.y}));
            end else if (phase <= 18) begin
                checkOutput("draw_cycle",
                    32'({bus.ld_x, bus.ld_y, bus.start_count, bus.done, bus.pix_idx, bus.data_out}),
                    32'({1'b0, 1'b0, 1'b1, 1'b0, 4'(phase - 3), 7'd0}));
            end else begin
                checkOutput("done_cycle",
                    32'({bus.ld_x, bus.ld_y, bus.start_count, bus.done, bus.pix_idx, bus.data_out}),
                    32'({1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 7'd0}));
            end
            phase++;
            if (phase == 20) begin
                phase    = -1;
                idle_cnt = 0;
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset held with both requesting, then continuous round-robin draws.
        resetn = 1'b0;
        applyStimulus(2'b11, 7'd10, 7'd20, 3'b101, 7'd127, 7'd127, 3'd3);
        cycles(3);
        pushExp(2'b01, 7'd10, 7'd20, 3'b101, 0);
        pushExp(2'b10, 7'd127, 7'd127, 3'd3, 0);
        pushExp(2'b01, 7'd10, 7'd20, 3'b101, 0);
        pushExp(2'b10, 7'd127, 7'd127, 3'd3, 0);
        resetn = 1'b1;
        waitPopped("rr_acks", 120);
        bus.req = 2'b00;
        waitIdle("rr_drain", 40);

        // Late request from requester 1 while requester 0 draws; operands of 0 change after ack.
        cycles(2);
        pushExp(2'b01, 7'd33, 7'd44, 3'd2, -1);
        applyStimulus(2'b01, 7'd33, 7'd44, 3'd2, 7'd5, 7'd6, 3'd1);
        waitPopped("late_ack0", 10);
        applyStimulus(2'b00, 7'd99, 7'd98, 3'd7, 7'd5, 7'd6, 3'd1);
        cycles(4);
        pushExp(2'b10, 7'd5, 7'd6, 3'd1, 0);
        bus.req = 2'b10;
        waitPopped("late_ack1", 40);
        bus.req = 2'b00;
        waitIdle("late_drain", 40);

        // Reset in the middle of a draw.
        cycles(2);
        pushExp(2'b01, 7'd1, 7'd2, 3'd6, -1);
        applyStimulus(2'b01, 7'd1, 7'd2, 3'd6, 7'd5, 7'd6, 3'd1);
        waitPopped("rst_ack0", 10);
        cycles(9);
        bus.req = 2'b00;
        resetn  = 1'b0;
        #1;
        checkOutput("async_reset",
            32'({bus.ack, bus.data_out, bus.ld_x, bus.ld_y, bus.start_count,
                 bus.pix_idx, bus.colour, bus.busy, bus.done}), 32'd0);
        cycles(2);
        resetn = 1'b1;
        cycles(25);
        checkOutput("post_reset_busy", 32'({bus.busy, bus.done}), 32'd0);
        checkOutput("post_reset_phase", 32'(phase < 0), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
